darkuart2: RTL and testbench
============================

# darkuart2

Parametrised successor UART for the darkriscv IO space. Adds runtime-programmable baud divisor, configurable-depth TX/RX FIFOs, false-start rejection, sticky overrun/framing error flags, maskable level IRQ and optional parity. Sits on the same single-word byte-lane IO slot as the current UART.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries per direction; legal range 1..8.
- DEFAULT_DIV, 16'd867: baud divisor after reset; bit time = DIV+1 cycles.
- PARITY_ODD, 0: parity sense when parity is compiled in; 1 = odd, 0 = even.
- CLK  in  1  clock; all logic on posedge.
- RESN  in  1  reset, asynchronous, active-low.
- RD  in  1  bus read strobe.
- WR  in  1  bus write strobe.
- BE  in  4  byte enables.
- DATAI  in  32  write data.
- DATAO  out  32  {DIV[15:0], RXHEAD[7:0], STATUS[7:0]}, combinational.
- IRQ  out  1  level interrupt request.
- RXD  in  1  serial receive line, idle high.
- TXD  out  1  serial transmit line, idle high.

## Operation
- STATUS: [0] TX FIFO full, [1] RX FIFO non-empty, [2] TX empty and transmitter idle, [3] RX overrun (sticky), [4] framing error (sticky), [5] parity error (sticky), [6] IE_RX, [7] IE_TXE.
- Write BE[0]: bits 6/7 load IE_RX/IE_TXE; writing 1 to bits 3/4/5 clears that flag; other bits ignored.
- Write BE[1]: push DATAI[15:8] into the TX FIFO. When full, the byte is dropped with no flag.
- Write BE[2]/BE[3]: load DIV[7:0]/DIV[15:8]. A new DIV takes effect at the next frame start on each side.
- Read BE[1]: pop the RX FIFO when non-empty. RXHEAD shows the head before the pop, and 8'h00 when empty.
- IRQ = (IE_RX & STATUS[1]) | (IE_TXE & STATUS[2]) | STATUS[3] | STATUS[4] | STATUS[5].
- TX FSM: IDLE, START, D0..D7, [PAR], STOP.
  - Transitions follow bit-counter expiry. STOP moves to START if the FIFO is non-empty, otherwise to IDLE. There is no idle gap between queued frames.
  - Data is sent LSB first. The byte pops from the FIFO on IDLE/STOP→START.
- RX FSM: IDLE, START, D0..D7, [PAR], STOP.
  - RXD passes through a 3-flop synchroniser, reset to all ones.
  - A falling edge in IDLE enters START and loads counter = DIV>>1.
  - At mid-start, RXD=1 is a false start: return to IDLE and push nothing.
  - Each later bit is sampled after DIV+1 cycles, at mid-bit.
  - At STOP sample: RXD=0 sets FE, but the byte is still pushed. If the RX FIFO is full, the byte is discarded and OVR is set. Then go to IDLE.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle are both honoured. This holds when full, and the count is unchanged.
  - A flag being set wins over a W1C clear in the same cycle.
- RESN low at any time: both FSMs go to IDLE, FIFOs empty, flags and enables clear, DIV=DEFAULT_DIV. An in-flight frame is abandoned.

## Timing
- Reset values: TXD=1, IRQ=0, DATAO={DEFAULT_DIV, 8'h00, 8'h04}.
- TX latency: write at edge n → TXD low (start bit) from edge n+2. Each bit lasts DIV+1 cycles.
- Frame length: 10 bits, or 11 with parity.
- RX latency: byte visible in RXHEAD and STATUS[1] one cycle after the STOP mid-bit sample.
- STATUS, RXHEAD and IRQ reflect register state combinationally. A pop is visible the cycle after the RD edge.
- Minimum supported DIV: 3.

## Configuration
- UART_PARITY_EN defined: one parity bit (PARITY_ODD sense) is sent and checked between D7 and STOP. A mismatch sets STATUS[5] and the byte is still pushed.
- UART_PARITY_EN undefined: 8N1 only; PAR states are absent and STATUS[5] reads 0.

## Structure
- Shared package darkuart2_pkg:
  - FSM state encodings.
  - STATUS bit indices.
  - BE lane assignments.
- One sub-module, darkuart2_fifo, instantiated twice (TX and RX).
  - Parameter: DEPTH_LOG2.
  - Ports: push/pop, data in, head out, full/empty.
  - Pointers are DEPTH_LOG2+1 bits wide with wrap-bit full/empty detection.

## Test plan
- Reset, then hold RESN high: DATAO=={16'd867,8'h00,8'h04}, TXD=1, IRQ=0.
- DIV=15, write 8'hA5: TXD low 2 cycles later, then bits 1,0,1,0,0,1,0,1, then stop, each 16 cycles; STATUS[2] returns to 1.
- DIV=15, DEPTH_LOG2=2, write 6 bytes back-to-back: STATUS[0] set after the 5th write (one byte already popped), 6th write dropped. Five frames leave contiguously with no idle gap.
- Loop TXD→RXD, send 8'h3C with IE_RX=1: IRQ rises, RXHEAD=8'h3C; a read with BE[1] clears STATUS[1] and IRQ.
- Drive a 4-cycle low glitch on RXD with DIV=15: no push, RX FSM back in IDLE. Then send 5 frames into a 4-deep FIFO: OVR=1, IRQ=1; W1C bit3 clears it.
- Frame with stop bit forced 0: FE=1 and byte pushed. With UART_PARITY_EN and a corrupted parity bit: STATUS[5]=1.

Source files
------------

// File: rtl/darkuart2_pkg.sv
// darkuart2_pkg: shared FSM encodings, STATUS bit indices and byte-lane map for darkuart2.
// UART_PARITY_EN adds the PAR state between the last data bit and STOP.
package darkuart2_pkg;
`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_PAR} uart_state_t;
    localparam uart_state_t S_AFTER_D = S_PAR;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
    localparam uart_state_t S_AFTER_D = S_STOP;
`endif
    localparam int ST_TXF = 0;
    localparam int ST_RXNE = 1;
    localparam int ST_TXE = 2;
    localparam int ST_OVR = 3;
    localparam int ST_FE = 4;
    localparam int ST_PE = 5;
    localparam int ST_IERX = 6;
    localparam int ST_IETXE = 7;
    localparam int BE_CTL = 0;
    localparam int BE_DAT = 1;
    localparam int BE_DIVL = 2;
    localparam int BE_DIVH = 3;
    function automatic logic parity(input logic [7:0] d, input logic odd);
        return ^d ^ odd;
    endfunction
endpackage

// File: rtl/darkuart2_if.sv
// darkuart2_if: IO-slot bus plus serial lines of darkuart2.
interface darkuart2_if;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] datai;
    logic [31:0] datao;
    logic        irq;
    logic        rxd;
    logic        txd;
    modport master (output rd, wr, be, datai, rxd, input datao, irq, txd);
    modport slave (input rd, wr, be, datai, rxd, output datao, irq, txd);
endinterface

// File: rtl/darkuart2_fifo.sv
// darkuart2_fifo: byte FIFO of 2**DEPTH_LOG2 entries using wrap-bit pointers.
module darkuart2_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    logic [DEPTH_LOG2:0] wr_q, rd_q;
    logic [7:0] mem_q [2**DEPTH_LOG2];
    logic do_push, do_pop;
    assign empty_o = wr_q == rd_q;
    assign full_o = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) && (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
    assign do_pop = pop_i && !empty_o;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o = mem_q[rd_q[DEPTH_LOG2-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= data_i;
    end
endmodule

// File: rtl/darkuart2.sv
// darkuart2: programmable-baud UART with TX/RX FIFOs, sticky error flags and level IRQ.
// Define UART_PARITY_EN for one parity bit (PARITY_ODD sense) per frame; default is 8N1.
module darkuart2 import darkuart2_pkg::*; #(
    parameter int          DEPTH_LOG2  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867,
    parameter bit          PARITY_ODD  = 1'b0
) (
    input logic       clk,
    input logic       rst_n,
    darkuart2_if.slave bus
);
    logic [15:0] div_q;
    logic ie_rx_q, ie_txe_q, ovr_q, fe_q, pe_q;
    logic [7:0] status;
    logic ctl_wr;
    logic tx_push, tx_pop, tx_full, tx_empty, txd_q;
    logic [7:0] tx_head;
    uart_state_t tx_st_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [8:0] tx_sh_q;
    logic [2:0] tx_bit_q;
    logic rx_push, rx_pop, rx_full, rx_empty, rx_fire, rxs, rx_prev_q;
    logic ovr_set, fe_set, pe_set;
    logic [7:0] rx_head, rx_sh_q;
    logic [2:0] rx_sync_q, rx_bit_q;
    uart_state_t rx_st_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    assign ctl_wr = bus.wr && bus.be[BE_CTL];
    assign tx_push = bus.wr && bus.be[BE_DAT];
    assign tx_pop = !tx_empty && (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_cnt_q == '0));
    darkuart2_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_pop), .data_i(bus.datai[15:8]),
        .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );
    // txd follows the state one cycle late; the parity bit rides in tx_sh_q[8]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q <= S_IDLE;
            tx_cnt_q <= '0;
            tx_div_q <= '0;
            tx_sh_q <= '0;
            tx_bit_q <= '0;
            txd_q <= 1'b1;
        end else begin
            txd_q <= tx_st_q == S_START ? 1'b0 : (tx_st_q == S_IDLE || tx_st_q == S_STOP) ? 1'b1 : tx_sh_q[0];
            if (tx_pop) begin
                tx_st_q <= S_START;
                tx_cnt_q <= div_q;
                tx_div_q <= div_q;
                tx_sh_q <= {parity(tx_head, PARITY_ODD), tx_head};
            end else if (tx_st_q != S_IDLE) begin
                tx_cnt_q <= tx_cnt_q == '0 ? tx_div_q : tx_cnt_q - 1'b1;
                if (tx_cnt_q == '0) begin
                    tx_st_q <= tx_st_q == S_START ? S_DATA :
                               tx_st_q == S_DATA ? (tx_bit_q == 3'd7 ? S_AFTER_D : S_DATA) :
                               tx_st_q == S_STOP ? S_IDLE : S_STOP;
                    tx_bit_q <= tx_st_q == S_DATA ? tx_bit_q + 1'b1 : 3'd0;
                    if (tx_st_q == S_DATA) tx_sh_q <= tx_sh_q >> 1;
                end
            end
        end
    end
    assign rxs = rx_sync_q[2];
    assign rx_fire = rx_st_q != S_IDLE && rx_cnt_q == '0;
    assign rx_push = rx_fire && rx_st_q == S_STOP;
    assign rx_pop = bus.rd && bus.be[BE_DAT] && !rx_empty;
    assign fe_set = rx_push && !rxs;
    assign ovr_set = rx_push && rx_full && !rx_pop;
`ifdef UART_PARITY_EN
    assign pe_set = rx_fire && rx_st_q == S_PAR && rxs != parity(rx_sh_q, PARITY_ODD);
`else
    assign pe_set = 1'b0;
`endif
    darkuart2_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(rx_push), .pop_i(rx_pop), .data_i(rx_sh_q),
        .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q <= '1;
            rx_prev_q <= 1'b1;
            rx_st_q <= S_IDLE;
            rx_cnt_q <= '0;
            rx_div_q <= '0;
            rx_sh_q <= '0;
            rx_bit_q <= '0;
        end else begin
            rx_sync_q <= {rx_sync_q[1:0], bus.rxd};
            rx_prev_q <= rxs;
            if (rx_st_q == S_IDLE) begin
                if (rx_prev_q && !rxs) begin
                    rx_st_q <= S_START;
                    rx_cnt_q <= div_q >> 1;
                    rx_div_q <= div_q;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 1'b1;
            end else begin
                rx_cnt_q <= rx_div_q;
                rx_st_q <= rx_st_q == S_START ? (rxs ? S_IDLE : S_DATA) :
                           rx_st_q == S_DATA ? (rx_bit_q == 3'd7 ? S_AFTER_D : S_DATA) :
                           rx_st_q == S_STOP ? S_IDLE : S_STOP;
                rx_bit_q <= rx_st_q == S_DATA ? rx_bit_q + 1'b1 : 3'd0;
                if (rx_st_q == S_DATA) rx_sh_q <= {rxs, rx_sh_q[7:1]};
            end
        end
    end
    // a flag being set overrides a same-cycle write-one-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DEFAULT_DIV;
            ie_rx_q <= 1'b0;
            ie_txe_q <= 1'b0;
            ovr_q <= 1'b0;
            fe_q <= 1'b0;
            pe_q <= 1'b0;
        end else begin
            if (ctl_wr) begin
                ie_rx_q <= bus.datai[ST_IERX];
                ie_txe_q <= bus.datai[ST_IETXE];
            end
            ovr_q <= ovr_set || (ovr_q && !(ctl_wr && bus.datai[ST_OVR]));
            fe_q <= fe_set || (fe_q && !(ctl_wr && bus.datai[ST_FE]));
            pe_q <= pe_set || (pe_q && !(ctl_wr && bus.datai[ST_PE]));
            if (bus.wr && bus.be[BE_DIVL]) div_q[7:0] <= bus.datai[23:16];
            if (bus.wr && bus.be[BE_DIVH]) div_q[15:8] <= bus.datai[31:24];
        end
    end
    always_comb begin
        status = '0;
        status[ST_TXF] = tx_full;
        status[ST_RXNE] = !rx_empty;
        status[ST_TXE] = tx_empty && tx_st_q == S_IDLE;
        status[ST_OVR] = ovr_q;
        status[ST_FE] = fe_q;
        status[ST_PE] = pe_q;
        status[ST_IERX] = ie_rx_q;
        status[ST_IETXE] = ie_txe_q;
    end
    assign bus.datao = {div_q, rx_empty ? 8'h00 : rx_head, status};
    assign bus.irq = (ie_rx_q && status[ST_RXNE]) || (ie_txe_q && status[ST_TXE]) || ovr_q || fe_q || pe_q;
    assign bus.txd = txd_q;
endmodule

// File: tb/tb_darkuart2.sv
// tb_darkuart2: random-data checks of darkuart2 against a frame-level model (DIV=15, 4-deep FIFOs).
module tb_darkuart2;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loop = 1'b0;
    logic rxd_drv = 1'b1;
    logic logging = 1'b0;
    logic txlog[$];
    int checks = 0;
    int errors = 0;
    darkuart2_if bus();
    assign bus.rxd = loop ? bus.txd : rxd_drv;
    darkuart2 #(.DEPTH_LOG2(2), .DEFAULT_DIV(16'd867), .PARITY_ODD(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        if (logging) txlog.push_back(bus.txd);
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [3:0] be, input logic [31:0] d);
        bus.wr = 1'b1;
        bus.be = be;
        bus.datai = d;
        @(negedge clk);
        bus.wr = 1'b0;
        bus.be = '0;
    endtask
    task automatic rd(output logic [31:0] d);
        bus.rd = 1'b1;
        bus.be = 4'b0010;
        d = bus.datao;
        @(negedge clk);
        bus.rd = 1'b0;
        bus.be = '0;
    endtask
    // serial frame, index 0 = start bit, LSB-first data, even parity, stop
    function automatic logic [10:0] frame(input logic [7:0] b, input logic stop);
`ifdef UART_PARITY_EN
        return {stop, ^b, b, 1'b0};
`else
        return {1'b0, stop, b, 1'b0};
`endif
    endfunction
    task automatic send_serial(input logic [10:0] f);
        for (int i = 0; i < FB; i++) begin
            rxd_drv = f[i];
            repeat (16) @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask
    // log[0] is TXD just after the write edge; frames must start 2 samples later and be contiguous
    task automatic check_frames(input string tag, input logic [7:0] exp_q[$]);
        int first = -1;
        int zeros = 0;
        for (int i = 0; i < txlog.size(); i++) begin
            if (txlog[i] == 1'b0) begin
                first = i;
                break;
            end
        end
        chk({tag, "_lat"}, first, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [10:0] got = '0;
            for (int i = 0; i < FB; i++) begin
                int idx = first + 8 + 16 * (k * FB + i);
                got[i] = (first >= 0 && idx < txlog.size()) ? txlog[idx] : 1'bx;
            end
            chk($sformatf("%s_frame%0d", tag, k), got, frame(exp_q[k], 1'b1));
        end
        for (int i = first + 16 * FB * exp_q.size(); i < txlog.size(); i++) if (i >= 0 && txlog[i] == 1'b0) zeros++;
        chk({tag, "_tail_idle"}, zeros, 0);
    endtask
    initial begin
        logic [31:0] d;
        logic [7:0] q[$];
        int n;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.be = '0;
        bus.datai = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_datao", bus.datao, {16'd867, 8'h00, 8'h04});
        chk("rst_txd", 32'(bus.txd), 1);
        chk("rst_irq", 32'(bus.irq), 0);
        wr(4'b1100, 32'h000F_0000);
        chk("div15", 32'(bus.datao[31:16]), 15);
        for (int t = 0; t < 3; t++) begin
            q.delete();
            q.push_back(t == 0 ? 8'hA5 : 8'($urandom));
            txlog.delete();
            logging = 1'b1;
            wr(4'b0010, {16'h0, q[0], 8'h00});
            repeat (FB * 16 + 30) @(negedge clk);
            logging = 1'b0;
            check_frames($sformatf("single%0d", t), q);
            chk($sformatf("txe_idle%0d", t), 32'(bus.datao[2]), 1);
        end
        q.delete();
        txlog.delete();
        logging = 1'b1;
        for (int i = 0; i < 6; i++) begin
            q.push_back(8'($urandom));
            wr(4'b0010, {16'h0, q[i], 8'h00});
            if (i == 3) chk("full_after4", 32'(bus.datao[0]), 0);
            if (i == 4) chk("full_after5", 32'(bus.datao[0]), 1);
        end
        repeat (5 * FB * 16 + 40) @(negedge clk);
        logging = 1'b0;
        void'(q.pop_back());
        check_frames("burst", q);
        chk("burst_txe", 32'(bus.datao[2]), 1);
        loop = 1'b1;
        wr(4'b0001, 32'h40);
        wr(4'b0010, 32'h3C00);
        n = 0;
        while (!bus.irq && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("lb_irq", 32'(bus.irq), 1);
        chk("lb_head", 32'(bus.datao[15:8]), 8'h3C);
        rd(d);
        chk("lb_rd", 32'(d[15:8]), 8'h3C);
        chk("lb_rxne_clr", 32'(bus.datao[1]), 0);
        chk("lb_irq_clr", 32'(bus.irq), 0);
        q.delete();
        for (int i = 0; i < 3; i++) begin
            q.push_back(8'($urandom));
            wr(4'b0010, {16'h0, q[i], 8'h00});
        end
        repeat (3 * FB * 16 + 40) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rd(d);
            chk($sformatf("lb_rand%0d", i), 32'(d[15:0]), {16'h0, q[i], 8'h46});
        end
        loop = 1'b0;
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_nopush", 32'(bus.datao[1]), 0);
        q.delete();
        for (int i = 0; i < 5; i++) begin
            q.push_back(8'($urandom));
            send_serial(frame(q[i], 1'b1));
        end
        repeat (10) @(negedge clk);
        chk("ovr_set", 32'(bus.datao[3]), 1);
        chk("ovr_irq", 32'(bus.irq), 1);
        wr(4'b0001, 32'h08);
        chk("ovr_clr", 32'(bus.datao[7:0]), 8'h06);
        chk("ovr_irq_clr", 32'(bus.irq), 0);
        for (int i = 0; i < 4; i++) begin
            rd(d);
            chk($sformatf("ovr_rd%0d", i), 32'(d[15:0]), {16'h0, q[i], 8'h06});
        end
        chk("ovr_drained", 32'(bus.datao[1]), 0);
        q.delete();
        q.push_back(8'($urandom));
        send_serial(frame(q[0], 1'b0));
        repeat (10) @(negedge clk);
        chk("fe_push", 32'(bus.datao[15:0]), {16'h0, q[0], 8'h16});
        chk("fe_irq", 32'(bus.irq), 1);
        wr(4'b0001, 32'h10);
        chk("fe_clr", 32'(bus.datao[7:0]), 8'h06);
        rd(d);
`ifdef UART_PARITY_EN
        send_serial(frame(8'h5A, 1'b1) ^ 11'h200);
        repeat (10) @(negedge clk);
        chk("pe_push", 32'(bus.datao[15:0]), {16'h0, 8'h5A, 8'h26});
        wr(4'b0001, 32'h20);
        rd(d);
`endif
        chk("final_idle", 32'(bus.datao[7:0]), 8'h04);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
